// File: rtl/ic_tester_pkg.sv
// Shared codes for the socket emulator: gate function select, per-gate
// fault select, channel state encoding, and the ideal-gate evaluator.
package ic_tester_pkg;

   typedef enum logic [2:0] {
      FN_AND  = 3'b000,
      FN_OR   = 3'b001,
      FN_NAND = 3'b010,
      FN_NOR  = 3'b011,
      FN_XOR  = 3'b100,
      FN_XNOR = 3'b101
   } fn_e;

   typedef enum logic [1:0] {
      FLT_NONE = 2'b00,
      FLT_SA0  = 2'b01,
      FLT_SA1  = 2'b10,
      FLT_INV  = 2'b11
   } flt_e;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_SETTLE = 1'b1
   } chan_st_e;

   // Codes 110/111 are not gate functions; they evaluate to 0.
   function automatic logic gate_eval(input logic [2:0] fn, input logic a,
                                      input logic b, input logic c);
      logic r;
      r = 1'b0;
      case (fn)
         FN_AND:  r = a & b & c;
         FN_OR:   r = a | b | c;
         FN_NAND: r = ~(a & b & c);
         FN_NOR:  r = ~(a | b | c);
         FN_XOR:  r = a ^ b ^ c;
         FN_XNOR: r = ~(a ^ b ^ c);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/emulated_gate_channel.sv
// One emulated gate output: holds the last accepted ideal value, only
// accepts a new value after it has stayed put for DELAY_CYCLES edges,
// and drives the pin through the fault map.
//   clk, reset    clock, async active-high reset
//   enable        low forces the channel idle with held = 0, op = 0
//   ideal         combinational gate result for this channel
//   fault_sel     00 none, 01 stuck-0, 10 stuck-1, 11 invert
//   op            registered pin output
//   chan_ok       channel is STABLE and ideal matches held
//
// state      | meaning
// ST_STABLE  | held is current; waiting for ideal to move
// ST_SETTLE  | ideal moved to target; timing out the settle window
module emulated_gate_channel
   import ic_tester_pkg::*;
#(
   parameter int DELAY_CYCLES = 4,
   parameter int CNT_W        = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       ideal,
   input  logic [1:0] fault_sel,
   output logic       op,
   output logic       chan_ok
);

   // Down-counter loaded with the remaining edges after the first; the
   // settle completes on the edge where it reads zero (edge n+DELAY_CYCLES).
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (DELAY_CYCLES > 0) ? CNT_W'(DELAY_CYCLES - 1) : '0;

   chan_st_e         state_q, state_d;
   logic             held_q, held_d;
   logic             target_q, target_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;

   always_comb begin
      state_d  = state_q;
      held_d   = held_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      if (!enable) begin
         state_d  = ST_STABLE;
         held_d   = 1'b0;
         target_d = 1'b0;
         cnt_d    = '0;
      end else begin
         case (state_q)
            ST_STABLE: begin
               if (ideal != held_q) begin
                  if (DELAY_CYCLES == 0) begin
                     held_d = ideal;
                  end else begin
                     target_d = ideal;
                     cnt_d    = CNT_LOAD;
                     state_d  = ST_SETTLE;
                  end
               end
            end
            ST_SETTLE: begin
               if (ideal == held_q) begin
                  // glitch returned to the held value: abandon the settle
                  cnt_d   = '0;
                  state_d = ST_STABLE;
               end else if (cnt_q == '0) begin
                  held_d  = target_q;
                  state_d = ST_STABLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = ST_STABLE;
         endcase
      end
   end

   // Fault map acts on next-held so fault changes bypass the settle delay.
   always_comb begin
      op_d = 1'b0;
      if (enable) begin
         case (fault_sel)
            FLT_NONE: op_d = held_d;
            FLT_SA0:  op_d = 1'b0;
            FLT_SA1:  op_d = 1'b1;
            FLT_INV:  op_d = ~held_d;
            default:  op_d = held_d;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_STABLE;
         held_q   <= 1'b0;
         target_q <= 1'b0;
         cnt_q    <= '0;
         op_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         held_q   <= held_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
      end
   end

   assign op      = op_q;
   assign chan_ok = (state_q == ST_STABLE) && (ideal == held_q);

endmodule

// File: rtl/ic_socket_emulator.sv
// Responder-side model of a 3-gate, 3-input logic IC sitting in the tester
// socket. Decodes the gate function, runs three independent settle/fault
// channels, and reports settled and invalid-function status.
//   clk, reset               clock, async active-high reset
//   enable                   emulator active; low forces idle
//   func_sel                 gate function (110/111 invalid)
//   fault_sel1..3            per-gate fault select
//   A1..C3                   tester-driven gate inputs
//   op1..op3                 registered gate outputs
//   settled                  registered: all channels stable (or idle)
//   func_err                 registered: func_sel is 110 or 111
module ic_socket_emulator
   import ic_tester_pkg::*;
#(
   parameter int DELAY_CYCLES = 4,
   parameter int CNT_W        = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] func_sel,
   input  logic [1:0] fault_sel1,
   input  logic [1:0] fault_sel2,
   input  logic [1:0] fault_sel3,
   input  logic       A1,
   input  logic       B1,
   input  logic       C1,
   input  logic       A2,
   input  logic       B2,
   input  logic       C2,
   input  logic       A3,
   input  logic       B3,
   input  logic       C3,
   output logic       op1,
   output logic       op2,
   output logic       op3,
   output logic       settled,
   output logic       func_err
);

   logic ideal1, ideal2, ideal3;
   logic ok1, ok2, ok3;
   logic settled_q, settled_d;
   logic func_err_q, func_err_d;

   assign ideal1 = gate_eval(func_sel, A1, B1, C1);
   assign ideal2 = gate_eval(func_sel, A2, B2, C2);
   assign ideal3 = gate_eval(func_sel, A3, B3, C3);

   emulated_gate_channel #(.DELAY_CYCLES(DELAY_CYCLES), .CNT_W(CNT_W)) u_ch1 (
      .clk(clk), .reset(reset), .enable(enable), .ideal(ideal1),
      .fault_sel(fault_sel1), .op(op1), .chan_ok(ok1)
   );

   emulated_gate_channel #(.DELAY_CYCLES(DELAY_CYCLES), .CNT_W(CNT_W)) u_ch2 (
      .clk(clk), .reset(reset), .enable(enable), .ideal(ideal2),
      .fault_sel(fault_sel2), .op(op2), .chan_ok(ok2)
   );

   emulated_gate_channel #(.DELAY_CYCLES(DELAY_CYCLES), .CNT_W(CNT_W)) u_ch3 (
      .clk(clk), .reset(reset), .enable(enable), .ideal(ideal3),
      .fault_sel(fault_sel3), .op(op3), .chan_ok(ok3)
   );

   // A disabled emulator is idle, so it reports settled.
   always_comb begin
      func_err_d = func_sel[2] & func_sel[1];
      settled_d  = ~enable | (ok1 & ok2 & ok3);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         settled_q  <= 1'b1;
         func_err_q <= 1'b0;
      end else begin
         settled_q  <= settled_d;
         func_err_q <= func_err_d;
      end
   end

   assign settled  = settled_q;
   assign func_err = func_err_q;

endmodule

// File: tb/tb_ic_socket_emulator.sv
module tb_ic_socket_emulator;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [2:0] func_sel;
   logic [1:0] fault_sel1, fault_sel2, fault_sel3;
   logic       A1, B1, C1, A2, B2, C2, A3, B3, C3;
   logic       op1, op2, op3;
   logic       settled;
   logic       func_err;

   int n_chk;
   int n_fail;

   ic_socket_emulator #(.DELAY_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .func_sel(func_sel),
      .fault_sel1(fault_sel1), .fault_sel2(fault_sel2), .fault_sel3(fault_sel3),
      .A1(A1), .B1(B1), .C1(C1), .A2(A2), .B2(B2), .C2(C2),
      .A3(A3), .B3(B3), .C3(C3),
      .op1(op1), .op2(op2), .op3(op3),
      .settled(settled), .func_err(func_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_pins(input logic [2:0] p1, input logic [2:0] p2, input logic [2:0] p3);
      {A1, B1, C1} = p1;
      {A2, B2, C2} = p2;
      {A3, B3, C3} = p3;
   endtask

   function automatic logic [2:0] ops();
      return {op3, op2, op1};
   endfunction

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset = 1'b1; enable = 1'b0; func_sel = 3'b000;
      fault_sel1 = 2'b00; fault_sel2 = 2'b00; fault_sel3 = 2'b00;
      set_pins(3'b000, 3'b000, 3'b000);
      step(2);
      chk("rst_ops", 32'(ops()), 32'h0);
      chk("rst_settled", 32'(settled), 32'h1);
      chk("rst_func_err", 32'(func_err), 32'h0);
      reset = 1'b0;
      step(1);

      // AND, channel 1 all ones: op1 rises on the 4th edge after first sample
      enable = 1'b1;
      set_pins(3'b111, 3'b000, 3'b000);
      step(1);
      chk("and_e1_ops", 32'(ops()), 32'h0);
      chk("and_e1_settled", 32'(settled), 32'h0);
      step(3);
      chk("and_e4_ops", 32'(ops()), 32'h0);
      chk("and_e4_settled", 32'(settled), 32'h0);
      step(1);
      chk("and_e5_ops", 32'(ops()), 32'h1);
      step(1);
      chk("and_settled", 32'(settled), 32'h1);

      // NAND: settle, then a 2-cycle glitch on channel 1 is rejected
      func_sel = 3'b010;
      step(6);
      chk("nand_ops", 32'(ops()), 32'h6);
      chk("nand_settled", 32'(settled), 32'h1);
      set_pins(3'b110, 3'b000, 3'b000);
      step(1);
      chk("glitch_e1_ops", 32'(ops()), 32'h6);
      chk("glitch_e1_settled", 32'(settled), 32'h0);
      step(1);
      chk("glitch_e2_ops", 32'(ops()), 32'h6);
      set_pins(3'b111, 3'b000, 3'b000);
      step(1);
      chk("glitch_back_ops", 32'(ops()), 32'h6);
      step(1);
      chk("glitch_settled", 32'(settled), 32'h1);
      step(4);
      chk("glitch_late_ops", 32'(ops()), 32'h6);

      // XOR, all pins 001, channel 2 inverted
      func_sel = 3'b100;
      fault_sel2 = 2'b11;
      set_pins(3'b001, 3'b001, 3'b001);
      step(1);
      chk("xor_e1_ops", 32'(ops()), 32'h4);
      step(5);
      chk("xor_ops", 32'(ops()), 32'h5);
      chk("xor_settled", 32'(settled), 32'h1);
      fault_sel2 = 2'b00;
      step(1);
      chk("xor_fault_clr_ops", 32'(ops()), 32'h7);

      // AND, pins 000, channel 3 stuck-1 then stuck-0
      func_sel = 3'b000;
      fault_sel3 = 2'b10;
      set_pins(3'b000, 3'b000, 3'b000);
      step(1);
      chk("sa1_e1_ops", 32'(ops()), 32'h7);
      step(5);
      chk("sa1_ops", 32'(ops()), 32'h4);
      fault_sel3 = 2'b01;
      step(1);
      chk("sa0_ops", 32'(ops()), 32'h0);
      fault_sel3 = 2'b00;

      // NOR to raise all outputs, then invalid function
      func_sel = 3'b011;
      step(6);
      chk("nor_ops", 32'(ops()), 32'h7);
      chk("nor_func_err", 32'(func_err), 32'h0);
      func_sel = 3'b111;
      step(1);
      chk("inv_e1_func_err", 32'(func_err), 32'h1);
      chk("inv_e1_ops", 32'(ops()), 32'h7);
      step(5);
      chk("inv_ops", 32'(ops()), 32'h0);
      chk("inv_func_err", 32'(func_err), 32'h1);

      // enable dropped mid-settle
      func_sel = 3'b011;
      step(2);
      chk("nor2_func_err", 32'(func_err), 32'h0);
      enable = 1'b0;
      step(1);
      chk("dis_ops", 32'(ops()), 32'h0);
      chk("dis_settled", 32'(settled), 32'h1);
      step(5);
      chk("dis_hold_ops", 32'(ops()), 32'h0);

      // enable dropped on the very edge the settle would complete
      enable = 1'b1;
      step(4);
      chk("re_e4_ops", 32'(ops()), 32'h0);
      chk("re_e4_settled", 32'(settled), 32'h0);
      enable = 1'b0;
      step(1);
      chk("prio_ops", 32'(ops()), 32'h0);
      chk("prio_settled", 32'(settled), 32'h1);
      enable = 1'b1;
      step(4);
      chk("re2_e4_ops", 32'(ops()), 32'h0);
      step(1);
      chk("re2_e5_ops", 32'(ops()), 32'h7);
      enable = 1'b0;
      step(1);
      chk("dis2_ops", 32'(ops()), 32'h0);
      enable = 1'b1;
      step(6);
      chk("re3_ops", 32'(ops()), 32'h7);

      // async reset in the middle of a settle on all channels
      func_sel = 3'b000;
      step(2);
      chk("pre_rst_ops", 32'(ops()), 32'h7);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_ops", 32'(ops()), 32'h0);
      chk("async_rst_settled", 32'(settled), 32'h1);
      step(2);
      reset = 1'b0;
      step(6);
      chk("post_rst_ops", 32'(ops()), 32'h0);
      chk("post_rst_settled", 32'(settled), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
